// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port data RAM between the CPU core (memory stage) and a
// host port used by the loader/debug logic. The core normally owns the RAM.
// A host request that keeps losing to the core is forced through after
// HOST_MAX_WAIT lost cycles, stalling the core for that one cycle.
//
// Parameters
//   HOST_MAX_WAIT  lost cycles before a pending host request is forced (1..15)
//   AW             RAM word-address width; RAM address = byte address [AW+1:2]
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   c_rd, c_wr          core read / write request (both high = write)
//   c_addr, c_wdata     core byte address / write data
//   c_rdata, c_stall    core read data (same cycle) / hold memory stage
//   h_req, h_we         host request / write-not-read
//   h_addr, h_wdata     host byte address / write data
//   h_gnt, h_err        host accepted / host address out of range
//   h_rvalid, h_rdata   host read response, one cycle after the grant
//   m_wren, m_addr      RAM write enable / word address
//   m_wdata, m_rdata    RAM write data / combinational read data

module dmem_arbiter #(
  parameter int HOST_MAX_WAIT = 4,
  parameter int AW            = 10
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          c_rd,
  input  logic          c_wr,
  input  logic [31:0]   c_addr,
  input  logic [31:0]   c_wdata,
  output logic [31:0]   c_rdata,
  output logic          c_stall,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [31:0]   h_addr,
  input  logic [31:0]   h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [31:0]   h_rdata,
  output logic          h_err,
  output logic          m_wren,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

  logic [3:0]    wait_cnt;
  logic          rvalid_q;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_wdata;

  logic core_act;
  logic host_win;
  logic grant;
  logic addr_bad;

  // Byte-lane bits and the core's upper address bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{c_addr[31:AW+2], c_addr[1:0], h_addr[1:0]};

  // Arbitration and RAM port steering. With no requester the address and
  // write data hold their last values so the RAM inputs do not toggle.
  always_comb begin
    core_act = c_rd | c_wr;
    host_win = h_req && (!core_act || (wait_cnt == MAX_WAIT));
    grant    = host_win && !RESET;
    addr_bad = (h_addr[31:AW+2] != '0);

    h_gnt   = grant;
    h_err   = grant && addr_bad;
    c_stall = grant && core_act;

    m_wren  = 1'b0;
    m_addr  = last_addr;
    m_wdata = last_wdata;

    if (!RESET) begin
      if (host_win) begin
        m_wren  = h_we && !addr_bad;
        m_addr  = h_addr[AW+1:2];
        m_wdata = h_wdata;
      end else if (core_act) begin
        m_wren  = c_wr;
        m_addr  = c_addr[AW+1:2];
        m_wdata = c_wdata;
      end
    end
  end

  // The core sees RAM data directly; it is only meaningful when not stalled.
  assign c_rdata = m_rdata;

  // A response registered at the grant edge would otherwise show up during
  // a reset cycle that immediately follows; masking it discards it.
  assign h_rvalid = rvalid_q && !RESET;

  // Remember the last driven RAM address/data for idle cycles.
  always_ff @(posedge CLK) begin
    last_addr  <= m_addr;
    last_wdata <= m_wdata;
  end

  // Host starvation counter. If the host is pending but not granted, the
  // core must be active, so every such cycle is a lost cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wait_cnt <= 4'd0;
    end else if (grant || !h_req) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != MAX_WAIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Host read response: one cycle after the grant, zero data on a range error.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rvalid_q <= 1'b0;
      h_rdata  <= 32'h0;
    end else begin
      rvalid_q <= grant && !h_we;
      if (grant && !h_we) begin
        h_rdata <= addr_bad ? 32'h0 : m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed stimulus for dmem_arbiter with a behavioural RAM attached.
// Each applied cycle pushes its expected outputs into exp_q; each expected
// host read response is pushed into rd_q. A monitor on the falling edge pops
// and compares, independently of the stimulus process.

module tb_dmem_arbiter;

  typedef struct {
    int          id;
    logic        gnt;
    logic        err;
    logic        stall;
    logic        wren;
    logic        rvalid;
    logic        chk_addr;
    logic [9:0]  addr;
    logic        chk_crd;
    logic [31:0] crd;
    logic        chk_hrd;
    logic [31:0] hrd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_rd, c_wr;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        c_stall;
  logic        h_req, h_we;
  logic [31:0] h_addr, h_wdata;
  logic        h_gnt, h_rvalid, h_err;
  logic [31:0] h_rdata;
  logic        m_wren;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  logic [31:0] ram [0:1023];
  logic        ram_init = 1'b1;

  exp_t        exp_q [$];
  logic [31:0] rd_q  [$];

  int n_checks = 0;
  int n_fail   = 0;
  int step     = 0;

  logic        pend_chk_addr = 1'b0;
  logic [9:0]  pend_addr     = '0;
  logic        pend_chk_crd  = 1'b0;
  logic [31:0] pend_crd      = '0;
  logic        pend_chk_hrd  = 1'b0;
  logic [31:0] pend_hrd      = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.HOST_MAX_WAIT(4), .AW(10)) dut (
    .CLK      (clk),
    .RESET    (reset),
    .c_rd     (c_rd),
    .c_wr     (c_wr),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_rdata  (c_rdata),
    .c_stall  (c_stall),
    .h_req    (h_req),
    .h_we     (h_we),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_gnt    (h_gnt),
    .h_rvalid (h_rvalid),
    .h_rdata  (h_rdata),
    .h_err    (h_err),
    .m_wren   (m_wren),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  // Behavioural RAM: combinational read, write at the clock edge, zeroed
  // on the first edge.
  assign m_rdata = ram[m_addr];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      ram_init <= 1'b0;
    end else if (m_wren) begin
      ram[m_addr] <= m_wdata;
    end
  end

  task automatic checkOutput(input int id, input string name,
                             input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL step %0d %s: got 0x%08h expected 0x%08h", id, name, act, expv);
    end
  endtask

  task automatic expAddr(input logic [9:0] a);
    pend_chk_addr = 1'b1;
    pend_addr     = a;
  endtask

  task automatic expCore(input logic [31:0] d);
    pend_chk_crd = 1'b1;
    pend_crd     = d;
  endtask

  task automatic expHost(input logic [31:0] d);
    pend_chk_hrd = 1'b1;
    pend_hrd     = d;
  endtask

  // Drives one cycle of inputs just after the rising edge and queues the
  // outputs expected during that cycle.
  task automatic applyStimulus(input logic rst, input logic crd, input logic cwr,
                               input logic [31:0] ca, input logic [31:0] cd,
                               input logic hreq, input logic hwe,
                               input logic [31:0] ha, input logic [31:0] hd,
                               input logic g, input logic er, input logic s,
                               input logic w, input logic v);
    exp_t e;
    @(posedge clk);
    #1;
    reset   = rst;
    c_rd    = crd;
    c_wr    = cwr;
    c_addr  = ca;
    c_wdata = cd;
    h_req   = hreq;
    h_we    = hwe;
    h_addr  = ha;
    h_wdata = hd;
    e.id       = step;
    e.gnt      = g;
    e.err      = er;
    e.stall    = s;
    e.wren     = w;
    e.rvalid   = v;
    e.chk_addr = pend_chk_addr;
    e.addr     = pend_addr;
    e.chk_crd  = pend_chk_crd;
    e.crd      = pend_crd;
    e.chk_hrd  = pend_chk_hrd;
    e.hrd      = pend_hrd;
    pend_chk_addr = 1'b0;
    pend_chk_crd  = 1'b0;
    pend_chk_hrd  = 1'b0;
    exp_q.push_back(e);
    step++;
  endtask

  // Monitor: compares per-cycle outputs and any host read response.
  always @(negedge clk) begin
    exp_t        cur;
    logic [31:0] d;
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      checkOutput(cur.id, "h_gnt",    32'(h_gnt),    32'(cur.gnt));
      checkOutput(cur.id, "h_err",    32'(h_err),    32'(cur.err));
      checkOutput(cur.id, "c_stall",  32'(c_stall),  32'(cur.stall));
      checkOutput(cur.id, "m_wren",   32'(m_wren),   32'(cur.wren));
      checkOutput(cur.id, "h_rvalid", 32'(h_rvalid), 32'(cur.rvalid));
      if (cur.chk_addr) checkOutput(cur.id, "m_addr",  32'(m_addr), 32'(cur.addr));
      if (cur.chk_crd)  checkOutput(cur.id, "c_rdata", c_rdata, cur.crd);
      if (cur.chk_hrd)  checkOutput(cur.id, "h_rdata_hold", h_rdata, cur.hrd);
    end
    if (h_rvalid === 1'b1) begin
      if (rd_q.size() == 0) begin
        checkOutput(step, "unexpected_h_rvalid", 32'h1, 32'h0);
      end else begin
        d = rd_q.pop_front();
        checkOutput(step, "h_rdata", h_rdata, d);
      end
    end
  end

  initial begin
    reset = 1'b1; c_rd = 1'b0; c_wr = 1'b0; c_addr = '0; c_wdata = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;

    // Reset cycles: all requests ignored, nothing written
    applyStimulus(1, 0,1,32'h0,32'hFFFFFFFF, 1,1,32'h0,32'hFFFFFFFF, 0,0,0,0,0);
    applyStimulus(1, 0,1,32'h0,32'hFFFFFFFF, 1,1,32'h0,32'hFFFFFFFF, 0,0,0,0,0);

    // Core write then same-cycle core read
    expHost(32'h0); expAddr(10'd4);
    applyStimulus(0, 0,1,32'h10,32'hA5A5A5A5, 0,0,32'h0,32'h0, 0,0,0,1,0);
    expCore(32'hA5A5A5A5); expAddr(10'd4);
    applyStimulus(0, 1,0,32'h10,32'h0, 0,0,32'h0,32'h0, 0,0,0,0,0);

    // Host read alone, response one cycle later, then data holds
    rd_q.push_back(32'hA5A5A5A5); expAddr(10'd4);
    applyStimulus(0, 0,0,32'h0,32'h0, 1,0,32'h10,32'h0, 1,0,0,0,0);
    expAddr(10'd4);
    applyStimulus(0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0,0,1);
    expHost(32'hA5A5A5A5);
    applyStimulus(0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0,0,0);

    // Out-of-range host read then write, back to back
    rd_q.push_back(32'h0);
    applyStimulus(0, 0,0,32'h0,32'h0, 1,0,32'h1000,32'h0, 1,1,0,0,0);
    applyStimulus(0, 0,0,32'h0,32'h0, 1,1,32'h1000,32'hDEADBEEF, 1,1,0,0,1);
    expCore(32'h0); expHost(32'h0);
    applyStimulus(0, 1,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0,0,0);

    // Host write starved by the core for four cycles, then forced
    for (int k = 0; k < 4; k++) begin
      expAddr(10'(16 + k));
      applyStimulus(0, 0,1,32'(64 + 4*k),32'(k + 1), 1,1,32'h20,32'h11111111, 0,0,0,1,0);
    end
    expAddr(10'd8);
    applyStimulus(0, 0,1,32'h50,32'd5, 1,1,32'h20,32'h11111111, 1,0,1,1,0);
    expAddr(10'h14);
    applyStimulus(0, 0,1,32'h50,32'd5, 0,0,32'h0,32'h0, 0,0,0,1,0);

    // Host read starved again from a cleared counter
    for (int k = 0; k < 4; k++) begin
      expCore(32'(k + 1));
      applyStimulus(0, 1,0,32'(64 + 4*k),32'h0, 1,0,32'h20,32'h0, 0,0,0,0,0);
    end
    rd_q.push_back(32'h11111111); expAddr(10'd8);
    applyStimulus(0, 1,0,32'h50,32'h0, 1,0,32'h20,32'h0, 1,0,1,0,0);
    expCore(32'd5); expAddr(10'h14);
    applyStimulus(0, 1,0,32'h50,32'h0, 0,0,32'h0,32'h0, 0,0,0,0,1);

    // Dropping h_req clears the counter: needs four fresh losses
    applyStimulus(0, 1,0,32'h40,32'h0, 1,0,32'h44,32'h0, 0,0,0,0,0);
    applyStimulus(0, 1,0,32'h40,32'h0, 1,0,32'h44,32'h0, 0,0,0,0,0);
    applyStimulus(0, 1,0,32'h40,32'h0, 0,0,32'h0,32'h0, 0,0,0,0,0);
    for (int k = 0; k < 4; k++) begin
      expCore(32'd1);
      applyStimulus(0, 1,0,32'h40,32'h0, 1,0,32'h44,32'h0, 0,0,0,0,0);
    end
    rd_q.push_back(32'd2);
    applyStimulus(0, 1,0,32'h40,32'h0, 1,0,32'h44,32'h0, 1,0,1,0,0);
    expCore(32'd1);
    applyStimulus(0, 1,0,32'h40,32'h0, 0,0,32'h0,32'h0, 0,0,0,0,1);

    // Core read+write together behaves as a write
    expAddr(10'h18);
    applyStimulus(0, 1,1,32'h60,32'h77, 0,0,32'h0,32'h0, 0,0,0,1,0);
    expCore(32'h77);
    applyStimulus(0, 1,0,32'h60,32'h0, 0,0,32'h0,32'h0, 0,0,0,0,0);

    // Reset right after a host read grant discards the response
    applyStimulus(0, 0,0,32'h0,32'h0, 1,0,32'h10,32'h0, 1,0,0,0,0);
    applyStimulus(1, 0,1,32'h10,32'hFFFFFFFF, 1,1,32'h10,32'hFFFFFFFF, 0,0,0,0,0);
    expHost(32'h0);
    applyStimulus(0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0,0,0);
    expCore(32'hA5A5A5A5);
    applyStimulus(0, 1,0,32'h10,32'h0, 1,0,32'h10,32'h0, 0,0,0,0,0);
    applyStimulus(0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0,0,0);

    @(negedge clk);
    #1;
    checkOutput(step, "rd_q_empty", 32'(rd_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter HOST_MAX_WAIT, default 4, the maximum consecutive cycles a pending host request loses to the core before the host is forced through (legal range 1..15).
REQ-002 The block SHALL have parameter AW, default 10, the RAM word-address width; the RAM address is byte address bits [AW+1:2].
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 c_rd  in  1  core data read request.
REQ-006 c_wr  in  1  core data write request.
REQ-007 c_addr  in  32  core byte address.
REQ-008 c_wdata  in  32  core write data.
REQ-009 c_rdata  out  32  core read data.
REQ-010 c_stall  out  1  core must hold its memory-stage instruction this cycle.
REQ-011 h_req  in  1  host (loader/debug) request.
REQ-012 h_we  in  1  host write (1) or read (0).
REQ-013 h_addr  in  32  host byte address.
REQ-014 h_wdata  in  32  host write data.
REQ-015 h_gnt  out  1  host request accepted this cycle.
REQ-016 h_rvalid  out  1  host read data valid.
REQ-017 h_rdata  out  32  host read data.
REQ-018 h_err  out  1  host access rejected (address out of range), same cycle as h_gnt.
REQ-019 m_wren  out  1  RAM write enable.
REQ-020 m_addr  out  AW  RAM word address.
REQ-021 m_wdata  out  32  RAM write data.
REQ-022 m_rdata  in  32  RAM read data, combinational from m_addr; writes take effect at the clock edge.

Function
REQ-023 Exactly one requester SHALL own the RAM port per cycle; the core is active when c_rd|c_wr, the host when h_req.
REQ-024 Only core active: the core SHALL own the port, c_stall=0, m_wren=c_wr, m_addr=c_addr[AW+1:2], c_rdata=m_rdata in the same cycle.
REQ-025 Only host active: the host SHALL own the port, h_gnt=1 combinationally in that cycle, m_wren=h_we&~h_err.
REQ-026 Both active, wait counter < HOST_MAX_WAIT: the core SHALL own the port, h_gnt=0, counter increments by 1.
REQ-027 Both active, wait counter = HOST_MAX_WAIT: the host SHALL own the port, c_stall=1, m_wren from host only, counter clears to 0.
REQ-028 The wait counter SHALL clear on any cycle where h_gnt=1 or h_req=0, and SHALL saturate at HOST_MAX_WAIT.
REQ-029 The host SHALL hold h_req, h_we, h_addr, h_wdata stable until h_gnt; the block makes no guarantee otherwise.
REQ-030 A granted host read SHALL register m_rdata into h_rdata and assert h_rvalid for exactly one cycle, the cycle after h_gnt (latency 1); granted writes SHALL NOT assert h_rvalid.
REQ-031 h_rdata SHALL hold its last value while h_rvalid=0.
REQ-032 h_err SHALL equal h_gnt & (h_addr[31:AW+2]!=0); an erroring request SHALL be granted, SHALL NOT write RAM, and a read error SHALL still produce h_rvalid with h_rdata=32'h0.
REQ-033 Core addresses SHALL NOT be range-checked; upper bits are ignored.
REQ-034 c_rd and c_wr both high SHALL be treated as a write.
REQ-035 Back-to-back host grants SHALL be allowed whenever the core is idle; a host grant and a pending h_rvalid in the same cycle are legal.
REQ-036 When no requester is active, m_wren=0 and m_addr/m_wdata SHALL hold their previous values.

Reset
REQ-037 While RESET=1 at a clock edge: wait counter=0, h_rvalid=0, h_rdata=0, and any in-flight host read response SHALL be discarded.
REQ-038 During the RESET=1 cycle, m_wren=0, h_gnt=0, h_err=0 and c_stall=0 regardless of requests.
REQ-039 The first cycle after RESET falls SHALL arbitrate normally with counter=0.

Verification
REQ-040 Core write addr 0x10 data 0xA5A5A5A5 alone -> m_wren=1, m_addr=4, c_stall=0; next-cycle core read 0x10 -> c_rdata=0xA5A5A5A5 same cycle.
REQ-041 Host read 0x10 alone -> h_gnt=1 same cycle, h_rvalid=1 with h_rdata=0xA5A5A5A5 next cycle, then h_rvalid=0.
REQ-042 Core requesting every cycle, host write held from cycle 0 -> core wins cycles 0-3, cycle 4 h_gnt=1 with c_stall=1, counter=0 at cycle 5.
REQ-043 Host read 0x1000 (AW=10) -> h_gnt=1 and h_err=1, m_wren=0, next cycle h_rvalid=1 with h_rdata=0.
REQ-044 RESET asserted the cycle after a host read grant -> h_rvalid stays 0, counter=0, no RAM write.
REQ-045 Random core/host traffic against a reference memory model -> every core read and every host h_rvalid data matches the model; no host request waits more than HOST_MAX_WAIT+1 cycles.
